// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one register file between two requesters
// (req0 = core datapath, req1 = debug/host loader).
//   accept (t) -> issue to register file (t+1) -> read response strobe (t+2)
// A requester may take exclusive ownership with reqN_lock. Ownership is
// force-released after LOCK_MAX held cycles, and the released requester
// must drop its lock for a cycle before it can own the file again.
// Optional macro RF_ZERO_GUARD_EN: writes to r0 are swallowed and flagged on
// a sticky zero_write_err output.

// Per-requester response register: one-cycle valid strobe, data held until
// the next response to the same requester.
module regfile_port_arbiter_resp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic [WIDTH-1:0] rd1_in,
  input  logic [WIDTH-1:0] rd2_in,
  output logic             valid,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;

  // Capture read data only when a read for this requester is issuing
  always_comb begin
    valid_d = strobe;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    if (strobe) begin
      rd1_d = rd1_in;
      rd2_d = rd2_in;
    end
  end

  // Response state, cleared so in-flight responses are dropped on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
    end
  end

  assign valid = valid_q;
  assign rd1   = rd1_q;
  assign rd2   = rd2_q;
endmodule

module regfile_port_arbiter #(
  parameter int WIDTH    = 16,
  parameter int REGBITS  = 4,
  parameter int LOCK_MAX = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_we,
  input  logic               req0_lock,
  input  logic [REGBITS-1:0] req0_ra1,
  input  logic [REGBITS-1:0] req0_ra2,
  input  logic [WIDTH-1:0]   req0_wd,
  output logic               resp0_valid,
  output logic [WIDTH-1:0]   resp0_rd1,
  output logic [WIDTH-1:0]   resp0_rd2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_we,
  input  logic               req1_lock,
  input  logic [REGBITS-1:0] req1_ra1,
  input  logic [REGBITS-1:0] req1_ra2,
  input  logic [WIDTH-1:0]   req1_wd,
  output logic               resp1_valid,
  output logic [WIDTH-1:0]   resp1_rd1,
  output logic [WIDTH-1:0]   resp1_rd2,
  output logic               rf_regwrite,
  output logic [REGBITS-1:0] rf_ra1,
  output logic [REGBITS-1:0] rf_ra2,
  output logic [WIDTH-1:0]   rf_wd,
  input  logic [WIDTH-1:0]   rf_rd1,
  input  logic [WIDTH-1:0]   rf_rd2,
`ifdef RF_ZERO_GUARD_EN
  output logic               zero_write_err,
`endif
  output logic               lock_timeout
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               last_grant_q, last_grant_d;
  logic [1:0]         relock_blk_q, relock_blk_d;
  logic               lock_timeout_q, lock_timeout_d;

  logic [1:0]                valid, lock, we, grant, acc;
  logic [1:0][REGBITS-1:0]   ra1, ra2;
  logic [1:0][WIDTH-1:0]     wd;
  logic                      acc_id, own_id;

  logic               iss_vld_q, iss_vld_d;
  logic               iss_we_q, iss_we_d;
  logic               iss_id_q, iss_id_d;
  logic [REGBITS-1:0] iss_ra1_q, iss_ra1_d;
  logic [REGBITS-1:0] iss_ra2_q, iss_ra2_d;
  logic [WIDTH-1:0]   iss_wd_q, iss_wd_d;
  logic               wr_allow;

  logic [1:0]            resp_valid;
  logic [1:0][WIDTH-1:0] resp_rd1, resp_rd2;

  assign valid = {req1_valid, req0_valid};
  assign lock  = {req1_lock, req0_lock};
  assign we    = {req1_we, req0_we};
  assign ra1   = {req1_ra1, req0_ra1};
  assign ra2   = {req1_ra2, req0_ra2};
  assign wd    = {req1_wd, req0_wd};

  // Grant: owner-exclusive when locked, else sole requester or alternate on tie
  always_comb begin
    grant = 2'b00;
    case (state_q)
      IDLE:    grant = (valid == 2'b11) ? (last_grant_q ? 2'b01 : 2'b10) : valid;
      OWN0:    grant = 2'b01;
      OWN1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Nothing is accepted while reset is asserted
  assign acc        = grant & valid & {2{reset_n}};
  assign req0_ready = acc[0];
  assign req1_ready = acc[1];
  assign acc_id     = acc[1];
  assign own_id     = (state_q == OWN1);

  // Lock ownership: entry on a locked accept, exit on lock drop or timeout.
  // The counter holds cycles already owned; releasing when it would reach
  // LOCK_MAX bounds ownership to exactly LOCK_MAX cycles.
  always_comb begin
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    last_grant_d   = last_grant_q;
    relock_blk_d   = relock_blk_q & lock;
    lock_timeout_d = 1'b0;
    if (|acc) last_grant_d = acc_id;
    case (state_q)
      IDLE: begin
        if ((|acc) && lock[acc_id] && !relock_blk_q[acc_id]) begin
          state_d    = acc_id ? OWN1 : OWN0;
          lock_cnt_d = '0;
        end
      end
      OWN0, OWN1: begin
        if (!lock[own_id]) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          state_d              = IDLE;
          lock_cnt_d           = '0;
          lock_timeout_d       = 1'b1;
          last_grant_d         = own_id;
          relock_blk_d[own_id] = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Arbitration / lock FSM state with registered timeout pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      lock_cnt_q     <= '0;
      last_grant_q   <= 1'b1;
      relock_blk_q   <= 2'b00;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      last_grant_q   <= last_grant_d;
      relock_blk_q   <= relock_blk_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  assign lock_timeout = lock_timeout_q;

  // Issue register: load the winner; addresses/data hold on idle cycles
  always_comb begin
    iss_vld_d = |acc;
    iss_we_d  = iss_we_q;
    iss_id_d  = iss_id_q;
    iss_ra1_d = iss_ra1_q;
    iss_ra2_d = iss_ra2_q;
    iss_wd_d  = iss_wd_q;
    if (|acc) begin
      iss_we_d  = we[acc_id];
      iss_id_d  = acc_id;
      iss_ra1_d = ra1[acc_id];
      iss_ra2_d = ra2[acc_id];
      iss_wd_d  = wd[acc_id];
    end
  end

  // Issue stage state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iss_vld_q <= 1'b0;
      iss_we_q  <= 1'b0;
      iss_id_q  <= 1'b0;
      iss_ra1_q <= '0;
      iss_ra2_q <= '0;
      iss_wd_q  <= '0;
    end else begin
      iss_vld_q <= iss_vld_d;
      iss_we_q  <= iss_we_d;
      iss_id_q  <= iss_id_d;
      iss_ra1_q <= iss_ra1_d;
      iss_ra2_q <= iss_ra2_d;
      iss_wd_q  <= iss_wd_d;
    end
  end

`ifdef RF_ZERO_GUARD_EN
  logic zero_hit, zero_err_q, zero_err_d;
  assign zero_hit = iss_vld_q & iss_we_q & (iss_ra2_q == '0);
  assign wr_allow = ~zero_hit;

  // Sticky flag for any write aimed at r0
  always_comb zero_err_d = zero_err_q | zero_hit;

  // Flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset_n) zero_err_q <= 1'b0;
    else          zero_err_q <= zero_err_d;
  end

  assign zero_write_err = zero_err_q;
`else
  assign wr_allow = 1'b1;
`endif

  // Write enable is gated by reset so a write issuing under reset never commits
  assign rf_regwrite = iss_vld_q & iss_we_q & wr_allow & reset_n;
  assign rf_ra1      = iss_ra1_q;
  assign rf_ra2      = iss_ra2_q;
  assign rf_wd       = iss_wd_q;

  for (genvar n = 0; n < 2; n++) begin : g_resp
    regfile_port_arbiter_resp #(.WIDTH(WIDTH)) u_resp (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (iss_vld_q & ~iss_we_q & (iss_id_q == (n == 1))),
      .rd1_in  (rf_rd1),
      .rd2_in  (rf_rd2),
      .valid   (resp_valid[n]),
      .rd1     (resp_rd1[n]),
      .rd2     (resp_rd2[n])
    );
  end

  assign resp0_valid = resp_valid[0];
  assign resp0_rd1   = resp_rd1[0];
  assign resp0_rd2   = resp_rd2[0];
  assign resp1_valid = resp_valid[1];
  assign resp1_rd1   = resp_rd1[1];
  assign resp1_rd2   = resp_rd2[1];
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Testbench for regfile_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_regfile_port_arbiter;
  localparam int W = 16, RB = 4, LM = 15;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic req0_valid, req0_ready, req0_we, req0_lock;
  logic [RB-1:0] req0_ra1, req0_ra2;
  logic [W-1:0] req0_wd;
  logic resp0_valid;
  logic [W-1:0] resp0_rd1, resp0_rd2;
  logic req1_valid, req1_ready, req1_we, req1_lock;
  logic [RB-1:0] req1_ra1, req1_ra2;
  logic [W-1:0] req1_wd;
  logic resp1_valid;
  logic [W-1:0] resp1_rd1, resp1_rd2;
  logic rf_regwrite;
  logic [RB-1:0] rf_ra1, rf_ra2;
  logic [W-1:0] rf_wd, rf_rd1, rf_rd2;
  logic lock_timeout;

  int errors = 0, checks = 0;

  regfile_port_arbiter #(.WIDTH(W), .REGBITS(RB), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_ra1(req0_ra1), .req0_ra2(req0_ra2), .req0_wd(req0_wd),
    .resp0_valid(resp0_valid), .resp0_rd1(resp0_rd1), .resp0_rd2(resp0_rd2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_ra1(req1_ra1), .req1_ra2(req1_ra2), .req1_wd(req1_wd),
    .resp1_valid(resp1_valid), .resp1_rd1(resp1_rd1), .resp1_rd2(resp1_rd2),
    .rf_regwrite(rf_regwrite), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wd(rf_wd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .lock_timeout(lock_timeout)
  );

  // Register file the arbiter drives: r0 reads as zero, writes at clock edge
  logic [W-1:0] rf_mem [16];
  logic preload = 1'b0;
  assign rf_rd1 = (rf_ra1 == '0) ? '0 : rf_mem[rf_ra1];
  assign rf_rd2 = (rf_ra2 == '0) ? '0 : rf_mem[rf_ra2];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 16'(i * 16'h1111);
    end else if (rf_regwrite && rf_ra2 != '0) begin
      rf_mem[rf_ra2] <= rf_wd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_ra1 = 0; req0_ra2 = 0; req0_wd = 0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_ra1 = 0; req1_ra2 = 0; req1_wd = 0;
  endtask

  // Two reset cycles with the register file reloaded to r[i] = i*0x1111
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; idle_inputs(); preload = 1;
    @(negedge clk);
    preload = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 0; idle_inputs(); req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    @(negedge clk); #1;
    checks++;
    if ({rf_regwrite, rf_ra1, rf_ra2, rf_wd, lock_timeout} !== '0) begin
      errors++; $display("FAIL reset_rf: got %b/%h/%h/%h/%b want 0", rf_regwrite, rf_ra1, rf_ra2, rf_wd, lock_timeout);
    end
    checks++;
    if ({resp0_valid, resp0_rd1, resp0_rd2, resp1_valid, resp1_rd1, resp1_rd2} !== '0) begin
      errors++; $display("FAIL reset_resp: got %b %h %h %b %h %h want 0", resp0_valid, resp0_rd1, resp0_rd2, resp1_valid, resp1_rd1, resp1_rd2);
    end
    idle_inputs();
    do_reset();
  endtask

  // Write r5, then read (r5, r0) right behind it
  task automatic test_write_read();
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_we = 1; req0_ra2 = 5; req0_wd = 16'h1234; #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL wr_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_we = 0; req0_ra1 = 5; req0_ra2 = 0; #1;
    checks++;
    if ({rf_regwrite, rf_ra2, rf_wd} !== {1'b1, 4'd5, 16'h1234}) begin
      errors++; $display("FAIL wr_issue: got %b %h %h want 1 5 1234", rf_regwrite, rf_ra2, rf_wd);
    end
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL rd_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0; #1;
    checks++;
    if ({rf_regwrite, resp0_valid} !== 2'b00) begin
      errors++; $display("FAIL rd_issue: got regwrite=%b resp=%b want 0 0", rf_regwrite, resp0_valid);
    end
    @(negedge clk); #1;
    checks++;
    if ({resp0_valid, resp0_rd1, resp0_rd2} !== {1'b1, 16'h1234, 16'h0000}) begin
      errors++; $display("FAIL rd_resp: got %b %h %h want 1 1234 0000", resp0_valid, resp0_rd1, resp0_rd2);
    end
    @(negedge clk); #1;
    checks++;
    if ({resp0_valid, resp0_rd1, resp0_rd2} !== {1'b0, 16'h1234, 16'h0000}) begin
      errors++; $display("FAIL rd_hold: got %b %h %h want 0 1234 0000", resp0_valid, resp0_rd1, resp0_rd2);
    end
  endtask

  // Write r7 at t, read r7 at t+1 from requester 1
  task automatic test_raw();
    do_reset();
    @(negedge clk);
    req1_valid = 1; req1_we = 1; req1_ra2 = 7; req1_wd = 16'hA5A5; #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL raw_wr_accept: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_we = 0; req1_ra1 = 7; req1_ra2 = 7; #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL raw_rd_accept: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk); #1;
    checks++;
    if ({resp1_valid, resp1_rd1, resp1_rd2, resp0_valid} !== {1'b1, 16'hA5A5, 16'hA5A5, 1'b0}) begin
      errors++; $display("FAIL raw_resp: got %b %h %h r0=%b want 1 a5a5 a5a5 0", resp1_valid, resp1_rd1, resp1_rd2, resp0_valid);
    end
  endtask

  // Both requesters read every cycle: grants alternate starting with req0
  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bit e0, e1, r0, r1;
      @(negedge clk);
      req0_valid = (i < 6); req0_ra1 = 1; req0_ra2 = 2;
      req1_valid = (i < 6); req1_ra1 = 3; req1_ra2 = 4;
      #1;
      e0 = (i < 6) && (i % 2 == 0);
      e1 = (i < 6) && (i % 2 == 1);
      r0 = (i >= 2) && (i - 2 < 6) && ((i - 2) % 2 == 0);
      r1 = (i >= 2) && (i - 2 < 6) && ((i - 2) % 2 == 1);
      checks++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        errors++; $display("FAIL alt_ready cyc=%0d: got %b%b want %b%b", i, req0_ready, req1_ready, e0, e1);
      end
      checks++;
      if ({resp0_valid, resp1_valid} !== {r0, r1}) begin
        errors++; $display("FAIL alt_resp cyc=%0d: got %b%b want %b%b", i, resp0_valid, resp1_valid, r0, r1);
      end
      if (r0) begin
        checks++;
        if ({resp0_rd1, resp0_rd2} !== {16'h1111, 16'h2222}) begin
          errors++; $display("FAIL alt_data0 cyc=%0d: got %h %h want 1111 2222", i, resp0_rd1, resp0_rd2);
        end
      end
      if (r1) begin
        checks++;
        if ({resp1_rd1, resp1_rd2} !== {16'h3333, 16'h4444}) begin
          errors++; $display("FAIL alt_data1 cyc=%0d: got %h %h want 3333 4444", i, resp1_rd1, resp1_rd2);
        end
      end
    end
  endtask

  // req1 locks with a write and holds 4 cycles; req0 waits until lock drops
  task automatic test_lock();
    do_reset();
    @(negedge clk);
    req1_valid = 1; req1_we = 1; req1_lock = 1; req1_ra2 = 3; req1_wd = 16'h00FF; #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL lock_accept: got %b want 1", req1_ready); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      req1_valid = 0; req1_lock = (i <= 4);
      req0_valid = 1; req0_we = 0; req0_ra1 = 1; req0_ra2 = 2; #1;
      checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL lock_block cyc=%0d: got %b want 0", i, req0_ready); end
      if (i == 1) begin
        checks++;
        if ({rf_regwrite, rf_ra2, rf_wd} !== {1'b1, 4'd3, 16'h00FF}) begin
          errors++; $display("FAIL lock_wr: got %b %h %h want 1 3 00ff", rf_regwrite, rf_ra2, rf_wd);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL lock_release: got %b want 1", req0_ready); end
  endtask

  // req0 holds its lock past LOCK_MAX owned cycles
  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_lock = 1; req1_valid = 1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL to_first: got %b%b want 10", req0_ready, req1_ready);
    end
    for (int i = 1; i <= LM; i++) begin
      @(negedge clk);
      req0_valid = 0; #1;
      checks++;
      if ({req1_ready, lock_timeout} !== 2'b00) begin
        errors++; $display("FAIL to_owned cyc=%0d: got ready1=%b tout=%b want 0 0", i, req1_ready, lock_timeout);
      end
    end
    @(negedge clk);
    req0_valid = 1; #1;
    checks++;
    if ({lock_timeout, req0_ready, req1_ready} !== 3'b101) begin
      errors++; $display("FAIL to_pulse: got tout=%b rdy=%b%b want 1 01", lock_timeout, req0_ready, req1_ready);
    end
    @(negedge clk);
    req1_valid = 0; #1;
    checks++;
    if ({lock_timeout, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL to_after: got tout=%b ready0=%b want 0 1", lock_timeout, req0_ready);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; #1;
    checks++;
    if (req1_ready !== 1'b1) begin errors++; $display("FAIL to_no_relock: got %b want 1", req1_ready); end
    @(negedge clk);
    req0_lock = 0; req1_valid = 0;
    @(negedge clk);
    req0_valid = 1; req0_lock = 1; #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL to_relock_acc: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; #1;
    checks++;
    if (req1_ready !== 1'b0) begin errors++; $display("FAIL to_relocked: got %b want 0", req1_ready); end
  endtask

  // Reset lands on the issue cycle of a write
  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_we = 0; req0_ra1 = 1; req0_ra2 = 2;
    @(negedge clk);
    req0_we = 1; req0_ra2 = 9; req0_wd = 16'hBEEF; #1;
    checks++;
    if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    reset_n = 0; req0_valid = 0; #1;
    checks++;
    if (rf_regwrite !== 1'b0) begin errors++; $display("FAIL mid_squash: got %b want 0", rf_regwrite); end
    @(negedge clk);
    reset_n = 1; #1;
    checks++;
    if ({rf_regwrite, rf_ra1, rf_ra2, rf_wd, lock_timeout, req0_ready, req1_ready,
         resp0_valid, resp0_rd1, resp0_rd2, resp1_valid, resp1_rd1, resp1_rd2} !== '0) begin
      errors++; $display("FAIL mid_zero: got rw=%b ra=%h/%h wd=%h resp=%b/%b rd0=%h/%h", rf_regwrite, rf_ra1, rf_ra2, rf_wd, resp0_valid, resp1_valid, resp0_rd1, resp0_rd2);
    end
    @(negedge clk); #1;
    checks++;
    if ({rf_mem[9], resp0_valid, rf_regwrite} !== {16'h9999, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_nowrite: got r9=%h resp=%b rw=%b want 9999 0 0", rf_mem[9], resp0_valid, rf_regwrite);
    end
  endtask

  // Random traffic against a transaction-level model of the arbiter
  task automatic test_random();
    int owner, cnt, last, win, nto;
    bit blk [2];
    logic [W-1:0] arch [16];
    bit e_wr [4]; logic [RB-1:0] e_wa [4]; logic [W-1:0] e_wd [4];
    bit e_rv [4]; int e_rid [4]; logic [W-1:0] e_r1 [4], e_r2 [4];
    logic [W-1:0] h1 [2], h2 [2];
    bit e_to;
    logic [1:0] lk;
    logic w_we; logic [RB-1:0] w_ra1, w_ra2; logic [W-1:0] w_wd;
    const int N = 900;
    do_reset();
    for (int i = 0; i < 16; i++) arch[i] = 16'(i * 16'h1111);
    for (int i = 0; i < 4; i++) begin e_wr[i] = 0; e_rv[i] = 0; e_rid[i] = 0; end
    owner = -1; cnt = 0; last = 1; blk[0] = 0; blk[1] = 0; e_to = 0;
    h1[0] = 0; h1[1] = 0; h2[0] = 0; h2[1] = 0;
    for (int c = 0; c < N; c++) begin
      int s;
      @(negedge clk);
      req0_valid = (c < N - 4) && ($urandom_range(0, 9) < 7);
      req1_valid = (c < N - 4) && ($urandom_range(0, 9) < 7);
      req0_we = $urandom_range(0, 1) != 0; req1_we = $urandom_range(0, 1) != 0;
      req0_ra1 = RB'($urandom_range(0, 15)); req0_ra2 = RB'($urandom_range(0, 15));
      req1_ra1 = RB'($urandom_range(0, 15)); req1_ra2 = RB'($urandom_range(0, 15));
      req0_wd = W'($urandom); req1_wd = W'($urandom);
      if ($urandom_range(0, 15) == 0) req0_lock = ~req0_lock;
      if ($urandom_range(0, 15) == 0) req1_lock = ~req1_lock;
      #1;
      win = -1;
      if (owner == -1) begin
        if (req0_valid && req1_valid) win = (last == 1) ? 0 : 1;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end else if (owner == 0 && req0_valid) win = 0;
      else if (owner == 1 && req1_valid) win = 1;
      s = c % 4;
      checks++;
      if ({req0_ready, req1_ready} !== {win == 0, win == 1}) begin
        errors++; $display("FAIL rand_ready cyc=%0d: got %b%b want %b%b", c, req0_ready, req1_ready, win == 0, win == 1);
      end
      checks++;
      if (lock_timeout !== e_to) begin
        errors++; $display("FAIL rand_timeout cyc=%0d: got %b want %b", c, lock_timeout, e_to);
      end
      checks++;
      if (rf_regwrite !== e_wr[s]) begin
        errors++; $display("FAIL rand_regwrite cyc=%0d: got %b want %b", c, rf_regwrite, e_wr[s]);
      end else if (e_wr[s]) begin
        checks++;
        if ({rf_ra2, rf_wd} !== {e_wa[s], e_wd[s]}) begin
          errors++; $display("FAIL rand_wr cyc=%0d: got %h %h want %h %h", c, rf_ra2, rf_wd, e_wa[s], e_wd[s]);
        end
      end
      if (e_rv[s]) begin h1[e_rid[s]] = e_r1[s]; h2[e_rid[s]] = e_r2[s]; end
      checks++;
      if ({resp0_valid, resp0_rd1, resp0_rd2} !== {e_rv[s] && e_rid[s] == 0, h1[0], h2[0]}) begin
        errors++; $display("FAIL rand_resp0 cyc=%0d: got %b %h %h want %b %h %h", c, resp0_valid, resp0_rd1, resp0_rd2, e_rv[s] && e_rid[s] == 0, h1[0], h2[0]);
      end
      checks++;
      if ({resp1_valid, resp1_rd1, resp1_rd2} !== {e_rv[s] && e_rid[s] == 1, h1[1], h2[1]}) begin
        errors++; $display("FAIL rand_resp1 cyc=%0d: got %b %h %h want %b %h %h", c, resp1_valid, resp1_rd1, resp1_rd2, e_rv[s] && e_rid[s] == 1, h1[1], h2[1]);
      end
      e_wr[s] = 0; e_rv[s] = 0;
      // clock edge: transaction bookkeeping
      if (win >= 0) begin
        w_we  = (win == 0) ? req0_we  : req1_we;
        w_ra1 = (win == 0) ? req0_ra1 : req1_ra1;
        w_ra2 = (win == 0) ? req0_ra2 : req1_ra2;
        w_wd  = (win == 0) ? req0_wd  : req1_wd;
        if (w_we) begin
          e_wr[(c + 1) % 4] = 1; e_wa[(c + 1) % 4] = w_ra2; e_wd[(c + 1) % 4] = w_wd;
          if (w_ra2 != 0) arch[w_ra2] = w_wd;
        end else begin
          e_rv[(c + 2) % 4] = 1; e_rid[(c + 2) % 4] = win;
          e_r1[(c + 2) % 4] = (w_ra1 == 0) ? '0 : arch[w_ra1];
          e_r2[(c + 2) % 4] = (w_ra2 == 0) ? '0 : arch[w_ra2];
        end
        last = win;
      end
      // clock edge: lock ownership bookkeeping
      lk = {req1_lock, req0_lock};
      nto = 0;
      if (owner == -1) begin
        if (win >= 0 && lk[win] && !blk[win]) begin owner = win; cnt = 0; end
      end else if (!lk[owner]) begin
        owner = -1;
      end else if (cnt + 1 == LM) begin
        nto = 1; last = owner; blk[owner] = 1; owner = -1;
      end else begin
        cnt++;
      end
      for (int n = 0; n < 2; n++) if (!lk[n]) blk[n] = 0;
      e_to = (nto != 0);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_raw();
    test_alternate();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the single 16-entry register file between two requesters: req0 (core datapath) and req1 (debug/host loader).
- Each requester issues read-pair or write transactions over a valid/ready handshake.
- The block registers the winning request, drives the register file's regwrite/ra1/ra2/wd, and returns rd1/rd2 with a response strobe.
- A lock input gives one requester exclusive ownership for atomic read-modify-write, with a timeout so it cannot starve the other requester.

Parameters:
WIDTH, 16, data width of the register file
REGBITS, 4, register address width
LOCK_MAX, 15, maximum consecutive cycles a lock may be held before forced release

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 transaction valid
req0_ready  output  1  requester 0 transaction accepted this cycle
req0_we  input  1  1 = write req0_wd to reg req0_ra2; 0 = read pair
req0_lock  input  1  request/hold exclusive ownership
req0_ra1  input  REGBITS  read address 1
req0_ra2  input  REGBITS  read address 2 / write address
req0_wd  input  WIDTH  write data
resp0_valid  output  1  one-cycle strobe, read data valid
resp0_rd1  output  WIDTH  read data 1
resp0_rd2  output  WIDTH  read data 2
req1_* / resp1_*  same set as requester 0
rf_regwrite  output  1  register file write enable
rf_ra1  output  REGBITS  register file read address 1
rf_ra2  output  REGBITS  register file read address 2 / write address
rf_wd  output  WIDTH  register file write data
rf_rd1  input  WIDTH  register file read data 1 (combinational)
rf_rd2  input  WIDTH  register file read data 2 (combinational)
lock_timeout  output  1  one-cycle pulse when a lock is force-released

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so req0 wins the first tie; lock counter 0.
- States:
  - IDLE: no owner.
  - OWN0, OWN1: the named requester holds the lock.
- Grant (combinational):
  - IDLE: a sole valid requester wins. If both are valid, the requester not equal to last_grant wins.
  - OWNn: only requester n may be granted; the other requester's ready is 0.
  - reqN_ready = grantN & reqN_valid. At most one ready is high per cycle.
- Accept at edge t (ready & valid):
  - Capture we/ra1/ra2/wd and the requester id into the issue register.
  - Set last_grant = id.
- Issue, cycle t+1:
  - rf_ra1/rf_ra2/rf_wd are driven from the issue register.
  - rf_regwrite = issued & we. The write commits at the end of t+1.
- Response, cycle t+2:
  - Reads only: rf_rd1/rf_rd2 are sampled at the end of t+1.
  - respN_valid is high for exactly one cycle in t+2, with data held until the next response to that requester.
  - Writes produce no response.
- Throughput: one transaction per cycle, back-to-back.
- Read-after-write: a read accepted at t+1 or later observes a write accepted at t.
- Idle issue cycle: rf_* addresses hold their last value and rf_regwrite=0.
- Lock transitions:
  - IDLE→OWNn when requester n is accepted with reqN_lock=1.
  - OWNn→IDLE when reqN_lock=0 at a clock edge.
  - Lock counter: increments each cycle in OWNn; reset to 0 on entry to OWNn.
  - When the counter reaches LOCK_MAX: force IDLE, pulse lock_timeout, set last_grant=n so the other requester wins the next tie.
  - The forced-release requester cannot re-lock until it has deasserted reqN_lock for at least one cycle.
- Reset mid-operation: the pipelined issue is squashed (rf_regwrite=0 the cycle after reset), pending responses are dropped, and the lock is released.
- Address 0: rd data passes through unchanged (the register file returns 0).

Optional Feature:
RF_ZERO_GUARD_EN
- Defined: a write to address 0 is accepted but rf_regwrite stays 0 in its issue cycle, and a sticky output zero_write_err (1 bit, cleared only by reset) is set.
- Undefined: writes to address 0 are forwarded normally, and the zero_write_err port does not exist.

Test Plan:
- Reset, then req0 writes 16'h1234 to r5, then reads ra1=5, ra2=0 → rf_regwrite is high one cycle after the write is accepted; resp0_valid fires 2 cycles after the read is accepted with rd1=16'h1234, rd2=0.
- Both requesters valid every cycle with reads → grants alternate 0,1,0,1; each resp arrives at accept+2; no cycle has both readies high.
- req1 locks and writes r3=16'h00FF, holds lock 4 cycles while req0 is valid → req0_ready=0 throughout; req0 is granted the cycle after req1_lock drops.
- req0 holds lock continuously with req1 valid → lock_timeout pulses after 15 owned cycles; the next grant goes to req1; req0 cannot re-lock until its lock drops.
- Write r7 accepted at t, read r7 accepted at t+1 → the read returns the new value.
- reset_n low during the issue cycle of a write → no rf_regwrite and no resp; all outputs 0 the following cycle.
